// File: rtl/ahb_arb_pkg.sv
// Shared definitions for the AHB bus arbiter: FSM states, AHB transfer and
// burst encodings, and the helper that maps a burst type to its beat count.
package ahb_arb_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE  = 2'd0,
        ARB_OWN   = 2'd1,
        ARB_BURST = 2'd2,
        ARB_LOCK  = 2'd3
    } arb_state_t;

    localparam logic [1:0] HTRANS_IDLE   = 2'd0;
    localparam logic [1:0] HTRANS_BUSY   = 2'd1;
    localparam logic [1:0] HTRANS_NONSEQ = 2'd2;
    localparam logic [1:0] HTRANS_SEQ    = 2'd3;

    localparam logic [2:0] HBURST_SINGLE = 3'd0;
    localparam logic [2:0] HBURST_INCR   = 3'd1;
    localparam logic [2:0] HBURST_WRAP4  = 3'd2;
    localparam logic [2:0] HBURST_INCR4  = 3'd3;
    localparam logic [2:0] HBURST_WRAP8  = 3'd4;
    localparam logic [2:0] HBURST_INCR8  = 3'd5;
    localparam logic [2:0] HBURST_WRAP16 = 3'd6;
    localparam logic [2:0] HBURST_INCR16 = 3'd7;

    // Beats in a burst; undefined-length INCR reports 0 so it never counts.
    function automatic logic [4:0] burst_beats(input logic [2:0] burst);
        case (burst)
            HBURST_SINGLE:               burst_beats = 5'd1;
            HBURST_WRAP4,  HBURST_INCR4:  burst_beats = 5'd4;
            HBURST_WRAP8,  HBURST_INCR8:  burst_beats = 5'd8;
            HBURST_WRAP16, HBURST_INCR16: burst_beats = 5'd16;
            default:                      burst_beats = 5'd0;
        endcase
    endfunction

endpackage

// File: rtl/ahb_arbiter_rr_picker.sv
// Combinational round-robin picker: finds the first requester after the
// pointer, wrapping around, so the pointer's own master is chosen last.
module rr_picker #(
    parameter int NUM_MASTERS = 4,
    parameter int MASTER_IDW  = 2
) (
    input  logic [NUM_MASTERS-1:0] req,
    input  logic [MASTER_IDW-1:0]  ptr,
    output logic [NUM_MASTERS-1:0] grant,
    output logic [MASTER_IDW-1:0]  index
);

    // Scan ptr+1 .. ptr+NUM_MASTERS modulo NUM_MASTERS and keep the first hit.
    always_comb begin
        int  idx;
        logic found;
        grant = '0;
        index = '0;
        found = 1'b0;
        idx   = 0;
        for (int k = 1; k <= NUM_MASTERS; k++) begin
            idx = (int'(ptr) + k) % NUM_MASTERS;
            if (!found && req[idx]) begin
                found = 1'b1;
                index = MASTER_IDW'(idx);
                grant[idx] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/ahb_arbiter.sv
// AHB bus arbiter with round-robin selection, fixed-length burst hold and
// locked-transfer hold. Optional tenure timeout for undefined-length bursts
// is enabled by defining the macro AHB_ARB_TIMEOUT_EN.
module ahb_arbiter
    import ahb_arb_pkg::*;
#(
    parameter int NUM_MASTERS    = 4,
    parameter int MASTER_IDW     = 2,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [NUM_MASTERS-1:0] HBUSREQ,
    input  logic [NUM_MASTERS-1:0] HLOCK,
    input  logic [1:0]             HTRANS,
    input  logic [2:0]             HBURST,
    input  logic                   HREADY,
    output logic [NUM_MASTERS-1:0] HGRANT,
    output logic [MASTER_IDW-1:0]  HMASTER,
    output logic [MASTER_IDW-1:0]  HMASTER_D,
    output logic                   HMASTLOCK
);

`ifdef AHB_ARB_TIMEOUT_EN
    localparam bit TIMEOUT_EN = 1'b1;
`else
    localparam bit TIMEOUT_EN = 1'b0;
`endif
    localparam int TOW = $clog2(TIMEOUT_CYCLES + 1);

    arb_state_t             state_q, next_state;
    logic [NUM_MASTERS-1:0] grant_q, next_grant;
    logic [MASTER_IDW-1:0]  owner_q, next_owner;
    logic [MASTER_IDW-1:0]  rr_ptr_q, next_rr;
    logic [3:0]             beat_cnt_q, next_cnt;
    logic [MASTER_IDW-1:0]  hmaster_q, hmaster_d_q;
    logic                   hmastlock_q;
    logic [TOW-1:0]         to_cnt_q;

    logic [NUM_MASTERS-1:0] pick_grant;
    logic [MASTER_IDW-1:0]  pick_index;
    logic                   on_bus;
    logic                   nonseq_ok;
    logic                   timeout_hit;
    logic                   rearb;

    rr_picker #(
        .NUM_MASTERS (NUM_MASTERS),
        .MASTER_IDW  (MASTER_IDW)
    ) u_picker (
        .req   (HBUSREQ),
        .ptr   (rr_ptr_q),
        .grant (pick_grant),
        .index (pick_index)
    );

    // Next-state, grant decision and beat counting; HTRANS-based decisions
    // wait until the granted master actually owns the address phase.
    always_comb begin
        next_state  = state_q;
        next_grant  = grant_q;
        next_owner  = owner_q;
        next_rr     = rr_ptr_q;
        next_cnt    = beat_cnt_q;
        rearb       = 1'b0;
        on_bus      = (owner_q == hmaster_q);
        nonseq_ok   = HREADY && (HTRANS == HTRANS_NONSEQ);
        timeout_hit = TIMEOUT_EN && on_bus && (int'(to_cnt_q) >= TIMEOUT_CYCLES) &&
                      ((HTRANS == HTRANS_IDLE) || (HTRANS == HTRANS_NONSEQ));

        case (state_q)
            ARB_IDLE: begin
                rearb = 1'b1;
            end
            ARB_OWN: begin
                if (HREADY) begin
                    if (on_bus && nonseq_ok && HLOCK[owner_q]) begin
                        next_state = ARB_LOCK;
                    end else if (on_bus && nonseq_ok && (burst_beats(HBURST) > 5'd1)) begin
                        next_cnt   = 4'(burst_beats(HBURST) - 5'd1);
                        next_state = ARB_BURST;
                    end else if (!HBUSREQ[owner_q] || timeout_hit ||
                                 (on_bus && ((HTRANS == HTRANS_IDLE) ||
                                  ((HTRANS == HTRANS_NONSEQ) && (HBURST == HBURST_SINGLE))))) begin
                        rearb = 1'b1;
                    end
                end
            end
            ARB_BURST: begin
                if (HREADY && (HTRANS == HTRANS_SEQ)) begin
                    if (beat_cnt_q <= 4'd1) begin
                        next_cnt   = 4'd0;
                        next_state = ARB_OWN;
                    end else begin
                        next_cnt = beat_cnt_q - 4'd1;
                    end
                end
            end
            ARB_LOCK: begin
                if (HREADY && !HLOCK[owner_q]) begin
                    next_state = ARB_OWN;
                end
            end
            default: begin
                next_state = ARB_IDLE;
            end
        endcase

        if (rearb) begin
            if (|HBUSREQ) begin
                next_grant = pick_grant;
                next_owner = pick_index;
                next_rr    = pick_index;
                next_state = ARB_OWN;
            end else begin
                next_grant = NUM_MASTERS'(1);
                next_owner = '0;
                next_state = ARB_IDLE;
            end
        end
    end

    // Arbitration registers; bus-phase owner tracking advances only on HREADY.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ARB_IDLE;
            grant_q     <= NUM_MASTERS'(1);
            owner_q     <= '0;
            rr_ptr_q    <= '0;
            beat_cnt_q  <= '0;
            hmaster_q   <= '0;
            hmaster_d_q <= '0;
            hmastlock_q <= 1'b0;
        end else begin
            state_q    <= next_state;
            grant_q    <= next_grant;
            owner_q    <= next_owner;
            rr_ptr_q   <= next_rr;
            beat_cnt_q <= next_cnt;
            if (HREADY) begin
                hmaster_q   <= owner_q;
                hmaster_d_q <= hmaster_q;
                hmastlock_q <= HLOCK[owner_q];
            end
        end
    end

    // Tenure counter for unlocked ownership; cleared outside ARB_OWN or on handover.
    always_ff @(posedge clk) begin
        if (reset) begin
            to_cnt_q <= '0;
        end else if ((state_q != ARB_OWN) || (next_owner != owner_q)) begin
            to_cnt_q <= '0;
        end else if (TIMEOUT_EN && HREADY && (int'(to_cnt_q) < TIMEOUT_CYCLES)) begin
            to_cnt_q <= to_cnt_q + 1'b1;
        end
    end

    assign HGRANT    = grant_q;
    assign HMASTER   = hmaster_q;
    assign HMASTER_D = hmaster_d_q;
    assign HMASTLOCK = hmastlock_q;

endmodule

// File: tb/tb_ahb_arbiter.sv
// Directed self-checking bench for ahb_arbiter: reset, round-robin rotation,
// burst hold, wait states, locked tenure, undefined-INCR tenure, parking.
module tb_ahb_arbiter;
    import ahb_arb_pkg::*;

    logic       clk;
    logic       reset;
    logic [3:0] HBUSREQ;
    logic [3:0] HLOCK;
    logic [1:0] HTRANS;
    logic [2:0] HBURST;
    logic       HREADY;
    logic [3:0] HGRANT;
    logic [1:0] HMASTER;
    logic [1:0] HMASTER_D;
    logic       HMASTLOCK;

    int vec_count  = 0;
    int miscompares = 0;

    ahb_arbiter #(
        .NUM_MASTERS    (4),
        .MASTER_IDW     (2),
        .TIMEOUT_CYCLES (8)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .HBUSREQ   (HBUSREQ),
        .HLOCK     (HLOCK),
        .HTRANS    (HTRANS),
        .HBURST    (HBURST),
        .HREADY    (HREADY),
        .HGRANT    (HGRANT),
        .HMASTER   (HMASTER),
        .HMASTER_D (HMASTER_D),
        .HMASTLOCK (HMASTLOCK)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive one cycle of inputs, then settle just after the rising edge.
    task automatic applyStimulus(input logic [3:0] req, input logic [3:0] lock,
                                 input logic [1:0] trans, input logic [2:0] burst,
                                 input logic ready);
        HBUSREQ = req;
        HLOCK   = lock;
        HTRANS  = trans;
        HBURST  = burst;
        HREADY  = ready;
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        vec_count++;
        assert (observed === expected) else begin
            miscompares++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [3:0] timeout_exp;
`ifdef AHB_ARB_TIMEOUT_EN
        timeout_exp = 4'b0001;
`else
        timeout_exp = 4'b0100;
`endif
        reset = 1'b1;
        applyStimulus(4'b1111, 4'b0000, HTRANS_IDLE, HBURST_SINGLE, 1'b1);
        applyStimulus(4'b1111, 4'b0000, HTRANS_IDLE, HBURST_SINGLE, 1'b1);
        checkOutput("reset_grant",   32'(HGRANT),    32'h1);
        checkOutput("reset_hmaster", 32'(HMASTER),   32'h0);
        checkOutput("reset_hmd",     32'(HMASTER_D), 32'h0);
        checkOutput("reset_lock",    32'(HMASTLOCK), 32'h0);

        // Round-robin: all request, each owner does a SINGLE then IDLE.
        reset = 1'b0;
        applyStimulus(4'b1111, 4'b0000, HTRANS_IDLE, HBURST_SINGLE, 1'b1);
        checkOutput("rr_grant1", 32'(HGRANT), 32'h2);
        checkOutput("rr_hm0",    32'(HMASTER), 32'h0);
        applyStimulus(4'b1111, 4'b0000, HTRANS_IDLE, HBURST_SINGLE, 1'b1);
        checkOutput("rr_hm1", 32'(HMASTER), 32'h1);
        applyStimulus(4'b1111, 4'b0000, HTRANS_NONSEQ, HBURST_SINGLE, 1'b1);
        checkOutput("rr_grant2", 32'(HGRANT), 32'h4);
        applyStimulus(4'b1111, 4'b0000, HTRANS_IDLE, HBURST_SINGLE, 1'b1);
        checkOutput("rr_hm2", 32'(HMASTER), 32'h2);
        applyStimulus(4'b1111, 4'b0000, HTRANS_NONSEQ, HBURST_SINGLE, 1'b1);
        checkOutput("rr_grant3", 32'(HGRANT), 32'h8);
        applyStimulus(4'b1111, 4'b0000, HTRANS_IDLE, HBURST_SINGLE, 1'b1);
        checkOutput("rr_hm3", 32'(HMASTER), 32'h3);
        applyStimulus(4'b1111, 4'b0000, HTRANS_NONSEQ, HBURST_SINGLE, 1'b1);
        checkOutput("rr_grant0", 32'(HGRANT), 32'h1);
        applyStimulus(4'b1111, 4'b0000, HTRANS_IDLE, HBURST_SINGLE, 1'b1);
        checkOutput("rr_hm0_again", 32'(HMASTER),   32'h0);
        checkOutput("rr_hmd3",      32'(HMASTER_D), 32'h3);

        // Burst hold: master 1 INCR8 with one BUSY, master 2 requests at beat 3.
        applyStimulus(4'b0010, 4'b0000, HTRANS_IDLE, HBURST_SINGLE, 1'b1);
        checkOutput("burst_grant1", 32'(HGRANT), 32'h2);
        applyStimulus(4'b0010, 4'b0000, HTRANS_IDLE, HBURST_SINGLE, 1'b1);
        checkOutput("burst_hm1", 32'(HMASTER), 32'h1);
        applyStimulus(4'b0010, 4'b0000, HTRANS_NONSEQ, HBURST_INCR8, 1'b1);
        applyStimulus(4'b0010, 4'b0000, HTRANS_SEQ,    HBURST_INCR8, 1'b1);
        applyStimulus(4'b0110, 4'b0000, HTRANS_SEQ,    HBURST_INCR8, 1'b1);
        checkOutput("burst_beat3", 32'(HGRANT), 32'h2);
        applyStimulus(4'b0110, 4'b0000, HTRANS_SEQ,    HBURST_INCR8, 1'b1);
        applyStimulus(4'b0110, 4'b0000, HTRANS_BUSY,   HBURST_INCR8, 1'b1);
        checkOutput("burst_busy", 32'(HGRANT), 32'h2);
        applyStimulus(4'b0110, 4'b0000, HTRANS_SEQ,    HBURST_INCR8, 1'b1);
        applyStimulus(4'b0110, 4'b0000, HTRANS_SEQ,    HBURST_INCR8, 1'b1);
        applyStimulus(4'b0110, 4'b0000, HTRANS_SEQ,    HBURST_INCR8, 1'b1);
        checkOutput("burst_beat7", 32'(HGRANT), 32'h2);
        applyStimulus(4'b0100, 4'b0000, HTRANS_SEQ,    HBURST_INCR8, 1'b1);
        checkOutput("burst_beat8_grant", 32'(HGRANT),  32'h2);
        checkOutput("burst_beat8_hm",    32'(HMASTER), 32'h1);
        applyStimulus(4'b0100, 4'b0000, HTRANS_IDLE, HBURST_SINGLE, 1'b1);
        checkOutput("burst_after_grant", 32'(HGRANT),  32'h4);
        checkOutput("burst_after_hm",    32'(HMASTER), 32'h1);
        applyStimulus(4'b0100, 4'b0000, HTRANS_IDLE, HBURST_SINGLE, 1'b1);
        checkOutput("burst_hm2",  32'(HMASTER),   32'h2);
        checkOutput("burst_hmd1", 32'(HMASTER_D), 32'h1);

        // Wait states during a 2 -> 3 handover.
        applyStimulus(4'b1100, 4'b0000, HTRANS_NONSEQ, HBURST_SINGLE, 1'b1);
        checkOutput("wait_grant3", 32'(HGRANT), 32'h8);
        for (int i = 0; i < 5; i++) begin
            applyStimulus(4'b1100, 4'b0000, HTRANS_IDLE, HBURST_SINGLE, 1'b0);
            checkOutput("wait_hm_hold",  32'(HMASTER),   32'h2);
            checkOutput("wait_hmd_hold", 32'(HMASTER_D), 32'h2);
        end
        applyStimulus(4'b1100, 4'b0000, HTRANS_IDLE, HBURST_SINGLE, 1'b1);
        checkOutput("wait_hm3",  32'(HMASTER),   32'h3);
        checkOutput("wait_hmd2", 32'(HMASTER_D), 32'h2);

        // Locked tenure: master 3 does two locked SINGLEs while master 0 requests.
        applyStimulus(4'b1001, 4'b1000, HTRANS_NONSEQ, HBURST_SINGLE, 1'b1);
        checkOutput("lock1_grant", 32'(HGRANT),    32'h8);
        checkOutput("lock1_mlock", 32'(HMASTLOCK), 32'h1);
        checkOutput("lock1_hmd3",  32'(HMASTER_D), 32'h3);
        applyStimulus(4'b1001, 4'b1000, HTRANS_NONSEQ, HBURST_SINGLE, 1'b1);
        checkOutput("lock2_grant", 32'(HGRANT),    32'h8);
        checkOutput("lock2_mlock", 32'(HMASTLOCK), 32'h1);
        applyStimulus(4'b1001, 4'b0000, HTRANS_NONSEQ, HBURST_SINGLE, 1'b1);
        checkOutput("unlock_grant", 32'(HGRANT),    32'h8);
        checkOutput("unlock_mlock", 32'(HMASTLOCK), 32'h0);
        applyStimulus(4'b1001, 4'b0000, HTRANS_IDLE, HBURST_SINGLE, 1'b1);
        checkOutput("unlock_grant0", 32'(HGRANT), 32'h1);
        applyStimulus(4'b1001, 4'b0000, HTRANS_IDLE, HBURST_SINGLE, 1'b1);
        checkOutput("unlock_hm0", 32'(HMASTER), 32'h0);

        // Undefined-length INCR tenure of master 2 while master 0 requests.
        applyStimulus(4'b0101, 4'b0000, HTRANS_IDLE, HBURST_SINGLE, 1'b1);
        checkOutput("incr_grant2", 32'(HGRANT), 32'h4);
        applyStimulus(4'b0101, 4'b0000, HTRANS_IDLE,   HBURST_SINGLE, 1'b1);
        applyStimulus(4'b0101, 4'b0000, HTRANS_NONSEQ, HBURST_INCR,   1'b1);
        for (int i = 0; i < 12; i++) begin
            applyStimulus(4'b0101, 4'b0000,
                          ((i % 4) == 0) ? HTRANS_NONSEQ : HTRANS_SEQ, HBURST_INCR, 1'b1);
        end
        checkOutput("incr_tenure", 32'(HGRANT), 32'(timeout_exp));

        // Parking with no requesters, then an idle-state grant under HREADY=0.
        applyStimulus(4'b0000, 4'b0000, HTRANS_IDLE, HBURST_SINGLE, 1'b1);
        checkOutput("park_grant", 32'(HGRANT), 32'h1);
        applyStimulus(4'b1000, 4'b0000, HTRANS_IDLE, HBURST_SINGLE, 1'b0);
        checkOutput("idle_wait_grant", 32'(HGRANT), 32'h8);

        // Reset abandons a locked burst.
        applyStimulus(4'b1000, 4'b0000, HTRANS_IDLE,   HBURST_SINGLE, 1'b1);
        applyStimulus(4'b1000, 4'b1000, HTRANS_NONSEQ, HBURST_INCR4,  1'b1);
        checkOutput("prelock_mlock", 32'(HMASTLOCK), 32'h1);
        reset = 1'b1;
        applyStimulus(4'b1111, 4'b1000, HTRANS_SEQ, HBURST_INCR4, 1'b1);
        checkOutput("rst_lock_grant", 32'(HGRANT),    32'h1);
        checkOutput("rst_lock_mlock", 32'(HMASTLOCK), 32'h0);
        checkOutput("rst_lock_hm",    32'(HMASTER),   32'h0);
        reset = 1'b0;
        applyStimulus(4'b0100, 4'b0000, HTRANS_IDLE, HBURST_SINGLE, 1'b1);
        checkOutput("post_rst_grant", 32'(HGRANT), 32'h4);

        $display("== %0d vectors applied, %0d miscompares ==", vec_count, miscompares);
        $finish;
    end

endmodule
